miss_req_queue: RTL and testbench
=================================

Name: miss_req_queue

Overview:
- Downstream stage of the instruction cache.
- Captures the 26-bit line addresses the cache emits on misses and evictions, buffers them in order, and presents them to the next-level cache over a valid/ready handshake.
- Coalesces back-to-back misses to the same line.
- Keeps drop, merge and issue counters for the statistics module.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..64)
- AW, 26, line-address width (address[31:6])
- PTR_W, 3, log2(DEPTH)
- CNT_W, 32, width of statistics counters

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear; driven high for one cycle on trace command n=8 (RESET)
- miss_valid  input  1  cache presents a miss line address this cycle
- miss_addr  input  AW  miss line address; sampled only when miss_valid=1 (may be Z/X otherwise)
- req_valid  output  1  head entry is available to the next level
- req_addr  output  AW  head entry line address
- req_ready  input  1  next level accepts head this cycle
- count  output  PTR_W+1  current occupancy, 0..DEPTH
- issued  output  CNT_W  requests handed off (req_valid & req_ready)
- merged  output  CNT_W  misses coalesced into an existing entry
- dropped  output  CNT_W  misses lost to overflow

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0; head and tail pointers 0; req_valid=0; req_addr=0.
  - issued=merged=dropped=0.
  - Storage contents need not be cleared.
  - Reset mid-handshake discards all entries. There is no partial request.
- First-word-fall-through:
  - req_valid = (count != 0).
  - req_addr = storage[head] combinationally. req_addr=0 when empty.
- Latency: a miss accepted at edge k is visible on req_valid/req_addr after edge k, i.e. one cycle.
- Dequeue: when req_valid & req_ready at an edge, head++ (wrapping modulo DEPTH), count--, issued++.
- Enqueue decision for miss_valid=1, evaluated in priority order:
  1. Merge: count!=0, and miss_addr equals the most recently written entry (storage[tail-1]), and that entry is not being dequeued this cycle. Result: no write; merged++.
  2. Accept: count<DEPTH, or a dequeue occurs in the same cycle. Result: write storage[tail], tail++ (wrapping), count++.
  3. Drop: otherwise. Result: no write; dropped++.
- Simultaneous enqueue and dequeue: count is unchanged.
  - When full, this accepts rather than drops.
  - When count=1 and the single entry equals miss_addr but is being dequeued, the new miss is accepted as a new entry, not merged.
- flush=1 has priority over everything in that cycle:
  - count, pointers and all counters cleared.
  - miss_valid and req_ready ignored.
  - issued is not incremented even if req_ready=1.
- Counters saturate at all-ones and never wrap.
- count never exceeds DEPTH and never underflows. req_ready with count=0 is a no-op.
- State machine: the occupancy state is EMPTY (count=0), PARTIAL, or FULL (count=DEPTH).
  - EMPTY→PARTIAL on accept.
  - PARTIAL→FULL on accept without dequeue at count=DEPTH-1.
  - FULL→PARTIAL on dequeue.
  - PARTIAL→EMPTY on dequeue without accept at count=1.
  - Any state→EMPTY on flush or reset.

Decomposition:
- Shared package cache_pkg:
  - Constants: LINE_AW=26, LINE_OFFSET=6, STAT_W=32.
  - Trace command codes: CMD_RESET=4'd8, CMD_INVALIDATE=4'd3, CMD_INST_FETCH=4'd2, CMD_PRINT=4'd9.
  - Typedef line_addr_t = logic [25:0].
- One sub-module, line_fifo: circular buffer with head/tail/count, FWFT read, push/pop/clear inputs, full/empty outputs.
- Merge comparison, drop decision and saturating counters live in miss_req_queue.

Test Plan:
1. Reset then idle: rst_n low 2 cycles → req_valid=0, count=0, issued=merged=dropped=0. Push 26'h0ABCDE with req_ready=0 → next cycle req_valid=1, req_addr=26'h0ABCDE, count=1.
2. Merge: push 26'h000100 twice on consecutive cycles, req_ready=0 → count=1, merged=1. Then push 26'h000200, then 26'h000100 → count=3, merged=1 (only the newest entry is compared).
3. Overflow, DEPTH=8, req_ready=0: push 10 distinct addresses 26'h10..26'h19 → count=8, dropped=2. Draining yields 26'h10..26'h17 in order; issued=8.
4. Full with simultaneous traffic: with count=8, push 26'h3FFFFFF and set req_ready=1 in the same cycle → dropped unchanged, count stays 8, issued+1, new entry at tail.
5. Same-line race: count=1 holding 26'h55, push 26'h55 with req_ready=1 → issued=1, merged=0, count=1, req_addr=26'h55 next cycle.
6. Flush and async reset mid-stream: with count=5, merged=3, flush=1 plus req_ready=1 and miss_valid=1 → next cycle count=0, all counters 0, issued not incremented. Then deassert rst_n between clock edges with count=4 → outputs clear immediately, without waiting for an edge.

Source files
------------

// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the instruction-cache blocks: line-address geometry,
//   statistics counter width, trace command codes and the occupancy states
//   used by the miss request queue.
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int unsigned LINE_AW     = 26;   // address[31:6]
    localparam int unsigned LINE_OFFSET = 6;    // byte offset bits within a line
    localparam int unsigned STAT_W      = 32;   // statistics counter width

    typedef enum logic [3:0] {
        CMD_INST_FETCH = 4'd2,
        CMD_INVALIDATE = 4'd3,
        CMD_RESET      = 4'd8,
        CMD_PRINT      = 4'd9
    } trace_cmd_e;

    typedef logic [LINE_AW-1:0] line_addr_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

endpackage

// File: rtl/miss_req_queue_line_fifo.sv
// ----------------------------------------------------------------------------
// line_fifo
//   Circular buffer of line addresses with first-word-fall-through read.
//   The caller only asserts push/pop when they are legal (no push when full
//   unless popping, no pop when empty); clear empties the buffer and wins over
//   push/pop. Occupancy is tracked by an EMPTY/PARTIAL/FULL state machine
//   that drives the full/empty flags.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous empty (pointers and count to 0)
//   push        : write push_data at tail
//   push_data   : entry to write
//   pop         : advance head
//   head_data   : entry at head, 0 when empty
//   last_data   : most recently written entry (tail-1)
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
// ----------------------------------------------------------------------------
module line_fifo
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = LINE_AW,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [AW-1:0]    push_data,
    input  logic             pop,
    output logic [AW-1:0]    head_data,
    output logic [AW-1:0]    last_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH - 1);

    logic [AW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_prev;
    occ_state_e       state;
    occ_state_e       state_next;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= OCC_EMPTY;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= OCC_EMPTY;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            state <= state_next;
        end
    end

    // Storage is not reset; stale entries are never visible since the
    // read side is gated by the empty flag.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[tail] <= push_data;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            OCC_EMPTY: begin
                if (push)
                    state_next = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push && !pop && count == CNT_LAST)
                    state_next = OCC_FULL;
                else if (pop && !push && count == CNT_ONE)
                    state_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push)
                    state_next = OCC_PARTIAL;
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    assign empty     = (state == OCC_EMPTY);
    assign full      = (state == OCC_FULL);
    assign tail_prev = tail - 1'b1;
    assign head_data = empty ? '0 : mem[head];
    assign last_data = mem[tail_prev];

endmodule

// File: rtl/miss_req_queue.sv
// ----------------------------------------------------------------------------
// miss_req_queue
//   Buffers cache miss/eviction line addresses in order and presents them to
//   the next-level cache over a valid/ready handshake (first-word-fall-
//   through). A miss matching the newest buffered line is coalesced into it.
//   Saturating counters report issued, merged and dropped requests.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of queue and counters; overrides all inputs
//   miss_valid : miss_addr carries a line address this cycle
//   miss_addr  : miss line address
//   req_valid  : head entry available
//   req_addr   : head entry line address (0 when empty)
//   req_ready  : next level accepts the head this cycle
//   count      : occupancy 0..DEPTH
//   issued     : handshakes completed
//   merged     : misses coalesced into the newest entry
//   dropped    : misses lost to overflow
// ----------------------------------------------------------------------------
module miss_req_queue
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = LINE_AW,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = STAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             miss_valid,
    input  logic [AW-1:0]    miss_addr,
    output logic             req_valid,
    output logic [AW-1:0]    req_addr,
    input  logic             req_ready,
    output logic [PTR_W:0]   count,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] merged,
    output logic [CNT_W-1:0] dropped
);

    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

    logic [AW-1:0] head_data;
    logic [AW-1:0] last_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          deq;
    logic          newest_leaving;
    logic          addr_match;
    logic          do_merge;
    logic          do_accept;
    logic          do_drop;

    line_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (do_accept),
        .push_data (miss_addr),
        .pop       (deq),
        .head_data (head_data),
        .last_data (last_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_valid = !fifo_empty;
    assign req_addr  = head_data;

    assign deq = !flush && req_valid && req_ready;

    // The newest entry is only leaving when it is also the head (count=1);
    // a matching miss must then become a new entry instead of merging.
    assign newest_leaving = deq && (count == CNT_ONE);
    assign addr_match     = (miss_addr == last_data);

    assign do_merge  = !flush && miss_valid && !fifo_empty && addr_match && !newest_leaving;
    assign do_accept = !flush && miss_valid && !do_merge && (!fifo_full || deq);
    assign do_drop   = !flush && miss_valid && !do_merge && !do_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued  <= '0;
            merged  <= '0;
            dropped <= '0;
        end else if (flush) begin
            issued  <= '0;
            merged  <= '0;
            dropped <= '0;
        end else begin
            if (deq && issued != '1)
                issued <= issued + 1'b1;
            if (do_merge && merged != '1)
                merged <= merged + 1'b1;
            if (do_drop && dropped != '1)
                dropped <= dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_miss_req_queue.sv
module tb_miss_req_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        miss_valid = 1'b0;
    logic [25:0] miss_addr = '0;
    logic        req_valid;
    logic [25:0] req_addr;
    logic        req_ready = 1'b0;
    logic [3:0]  count;
    logic [31:0] issued;
    logic [31:0] merged;
    logic [31:0] dropped;

    int errors = 0;
    int checks = 0;

    logic [25:0] sb[$];
    int unsigned exp_issued;
    int unsigned exp_merged;
    int unsigned exp_dropped;

    miss_req_queue #(
        .DEPTH (8),
        .AW    (26),
        .PTR_W (3),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .count      (count),
        .issued     (issued),
        .merged     (merged),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one cycle of stimulus and advances the reference model, which
    // keeps the expected in-order contents in the scoreboard queue.
    task automatic step(input logic mv, input logic [25:0] a, input logic rr, input logic fl);
        int n;
        logic d, m, acc;
        n = sb.size();
        miss_valid = mv;
        miss_addr  = mv ? a : 'x;
        req_ready  = rr;
        flush      = fl;
        if (fl) begin
            sb.delete();
            exp_issued  = 0;
            exp_merged  = 0;
            exp_dropped = 0;
        end else begin
            d   = rr && (n != 0);
            m   = mv && (n != 0) && (a == sb[n-1]) && !(d && n == 1);
            acc = mv && !m && ((n < DEPTH) || d);
            if (d) begin
                void'(sb.pop_front());
                exp_issued++;
            end
            if (m) exp_merged++;
            if (acc) sb.push_back(a);
            if (mv && !m && !acc) exp_dropped++;
        end
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
        miss_addr  = 'x;
        req_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        miss_valid = 1'b0;
        req_ready  = 1'b0;
        flush      = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_issued  = 0;
        exp_merged  = 0;
        exp_dropped = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (req_addr !== 26'd0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", req_addr); end
        checks++; if (issued !== 32'd0 || merged !== 32'd0 || dropped !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", issued, merged, dropped);
        end
        rst_n = 1'b1;
        sb.delete();
        exp_issued = 0; exp_merged = 0; exp_dropped = 0;
        // ready with nothing queued must not issue
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== 4'd0 || issued !== 32'd0) begin
            errors++; $display("FAIL empty_ready: got count=%0d issued=%0d expected 0/0", count, issued);
        end
        step(1'b1, 26'h0ABCDE, 1'b0, 1'b0);
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== sb[0]) begin errors++; $display("FAIL first_addr: got %h expected %h", req_addr, sb[0]); end
        checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL first_count: got %0d expected %0d", count, sb.size()); end
    endtask

    task automatic test_merge();
        do_reset();
        step(1'b1, 26'h000100, 1'b0, 1'b0);
        step(1'b1, 26'h000100, 1'b0, 1'b0);
        checks++; if (count !== 4'(sb.size()) || count !== 4'd1) begin
            errors++; $display("FAIL merge_count: got %0d expected %0d", count, sb.size());
        end
        checks++; if (merged !== 32'(exp_merged)) begin errors++; $display("FAIL merge_merged: got %0d expected %0d", merged, exp_merged); end
        step(1'b1, 26'h000200, 1'b0, 1'b0);
        step(1'b1, 26'h000100, 1'b0, 1'b0);
        checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL merge_newest_count: got %0d expected %0d", count, sb.size()); end
        checks++; if (merged !== 32'(exp_merged)) begin errors++; $display("FAIL merge_newest_merged: got %0d expected %0d", merged, exp_merged); end
        for (int k = 0; k < 16 && sb.size() != 0; k++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== sb[0]) begin
                errors++; $display("FAIL merge_drain: got v=%b addr=%h expected v=1 addr=%h", req_valid, req_addr, sb[0]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (req_valid !== 1'b0 || issued !== 32'(exp_issued)) begin
            errors++; $display("FAIL merge_empty: got v=%b issued=%0d expected v=0 issued=%0d", req_valid, issued, exp_issued);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 26'(32'h10 + i), 1'b0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (dropped !== 32'(exp_dropped)) begin errors++; $display("FAIL ovf_dropped: got %0d expected %0d", dropped, exp_dropped); end
        for (int k = 0; k < 16 && sb.size() != 0; k++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== sb[0]) begin
                errors++; $display("FAIL ovf_drain: got v=%b addr=%h expected v=1 addr=%h", req_valid, req_addr, sb[0]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (issued !== 32'(exp_issued)) begin errors++; $display("FAIL ovf_issued: got %0d expected %0d", issued, exp_issued); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_full_traffic();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 26'(32'h20 + i), 1'b0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
        checks++; if (req_addr !== sb[0]) begin errors++; $display("FAIL full_head: got %h expected %h", req_addr, sb[0]); end
        step(1'b1, 26'h3FFFFFF, 1'b1, 1'b0);
        checks++; if (count !== 4'(sb.size()) || count !== 4'd8) begin
            errors++; $display("FAIL full_swap_count: got %0d expected %0d", count, sb.size());
        end
        checks++; if (dropped !== 32'(exp_dropped) || issued !== 32'(exp_issued)) begin
            errors++; $display("FAIL full_swap_counters: got dropped=%0d issued=%0d expected %0d/%0d", dropped, issued, exp_dropped, exp_issued);
        end
        for (int k = 0; k < 16 && sb.size() != 0; k++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== sb[0]) begin
                errors++; $display("FAIL full_drain: got v=%b addr=%h expected v=1 addr=%h", req_valid, req_addr, sb[0]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_race();
        do_reset();
        step(1'b1, 26'h55, 1'b0, 1'b0);
        step(1'b1, 26'h55, 1'b1, 1'b0);
        checks++; if (issued !== 32'(exp_issued)) begin errors++; $display("FAIL race_issued: got %0d expected %0d", issued, exp_issued); end
        checks++; if (merged !== 32'(exp_merged)) begin errors++; $display("FAIL race_merged: got %0d expected %0d", merged, exp_merged); end
        checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL race_count: got %0d expected %0d", count, sb.size()); end
        checks++; if (req_valid !== 1'b1 || req_addr !== sb[0]) begin
            errors++; $display("FAIL race_addr: got v=%b addr=%h expected v=1 addr=%h", req_valid, req_addr, sb[0]);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 26'(32'h40 + i), 1'b0, 1'b0);
            if (i < 3) step(1'b1, 26'(32'h40 + i), 1'b0, 1'b0);
        end
        checks++; if (count !== 4'(sb.size()) || merged !== 32'(exp_merged)) begin
            errors++; $display("FAIL flush_setup: got count=%0d merged=%0d expected %0d/%0d", count, merged, sb.size(), exp_merged);
        end
        step(1'b1, 26'h77, 1'b1, 1'b1);
        checks++; if (count !== 4'd0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL flush_queue: got count=%0d v=%b expected 0/0", count, req_valid);
        end
        checks++; if (issued !== 32'd0 || merged !== 32'd0 || dropped !== 32'd0) begin
            errors++; $display("FAIL flush_counters: got %0d/%0d/%0d expected 0/0/0", issued, merged, dropped);
        end
        step(1'b1, 26'h61, 1'b0, 1'b0);
        step(1'b1, 26'h61, 1'b0, 1'b0);
        for (int i = 2; i < 6; i++) step(1'b1, 26'(32'h60 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== 4'(sb.size()) || issued !== 32'(exp_issued) || merged !== 32'(exp_merged)) begin
            errors++; $display("FAIL prereset_state: got count=%0d issued=%0d merged=%0d expected %0d/%0d/%0d",
                               count, issued, merged, sb.size(), exp_issued, exp_merged);
        end
        // assert reset between edges; outputs must clear without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || req_valid !== 1'b0 || req_addr !== 26'd0) begin
            errors++; $display("FAIL async_reset_queue: got count=%0d v=%b addr=%h expected 0/0/0", count, req_valid, req_addr);
        end
        checks++; if (issued !== 32'd0 || merged !== 32'd0 || dropped !== 32'd0) begin
            errors++; $display("FAIL async_reset_counters: got %0d/%0d/%0d expected 0/0/0", issued, merged, dropped);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_issued = 0; exp_merged = 0; exp_dropped = 0;
    endtask

    initial begin
        test_reset();
        test_merge();
        test_overflow();
        test_full_traffic();
        test_race();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
